// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Collects asynchronous and synchronous reset requests and turns them into a
//   stretched, staged set of synchronous reset outputs. It also keeps a sticky
//   record of which sources caused a reset.
//
// Ports
//   i_clk         sole clock, rising edge
//   i_rst_n       synchronous active-low reset (treated as power-on cause)
//   i_req_async   asynchronous level reset requests, one per source
//   i_req_strobe  synchronous single-cycle reset command
//   i_src_mask    1 = ignore the matching i_req_async bit
//   i_cause_clr   synchronous clear of the cause register
//   o_reset_out   registered active-high resets; bit 0 is released first
//   o_busy        high whenever the sequencer is not idle
//   o_cause       sticky cause: [0] power-on, [1] strobe, [2+i] i_req_async[i]
module reset_sequencer #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned NUM_OUT        = 3,
    parameter int unsigned RELEASE_GAP    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_req_async,
    input  logic               i_req_strobe,
    input  logic [NUM_SRC-1:0] i_src_mask,
    input  logic               i_cause_clr,
    output logic [NUM_OUT-1:0] o_reset_out,
    output logic               o_busy,
    output logic [NUM_SRC+1:0] o_cause
);

    localparam int unsigned CauseW = NUM_SRC + 2;
    // Counters only need to reach their terminal value (max-1), never wrap.
    localparam int unsigned CntW   = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int unsigned GapW   = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
    localparam int unsigned StageW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CntW-1:0]   CntLast   = CntW'(STRETCH_CYCLES - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(RELEASE_GAP - 1);
    localparam logic [StageW-1:0] StageLast = StageW'(NUM_OUT - 1);

    typedef enum logic [1:0] {StAssert, StRelease, StIdle} state_e;

    logic [NUM_SRC-1:0][SYNC_STAGES-1:0] r_sync;
    state_e                              r_state;
    state_e                              w_state_d;
    logic [CntW-1:0]                     r_cnt;
    logic [CntW-1:0]                     w_cnt_d;
    logic [GapW-1:0]                     r_gap;
    logic [GapW-1:0]                     w_gap_d;
    logic [StageW-1:0]                   r_stage;
    logic [StageW-1:0]                   w_stage_d;
    logic [NUM_OUT-1:0]                  r_reset_out;
    logic [NUM_OUT-1:0]                  w_reset_d;
    logic [CauseW-1:0]                   r_cause;
    logic [CauseW-1:0]                   w_cause_d;
    logic [NUM_SRC-1:0]                  w_sync_out;
    logic [NUM_SRC-1:0]                  w_src_hit;
    logic                                w_req;

    // Per-source synchroniser; masking is applied only on its output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], i_req_async[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_sync_out[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    assign w_src_hit = w_sync_out & ~i_src_mask;
    assign w_req     = (|w_src_hit) | i_req_strobe;

    // Cause bits set in the same cycle as a clear take priority.
    assign w_cause_d = (i_cause_clr ? '0 : r_cause) | {w_src_hit, i_req_strobe, 1'b0};

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StAssert;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_stage     <= '0;
            r_reset_out <= '1;
            r_cause     <= CauseW'(1);
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_gap       <= w_gap_d;
            r_stage     <= w_stage_d;
            r_reset_out <= w_reset_d;
            r_cause     <= w_cause_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StAssert: begin
                if (!w_req && r_cnt == CntLast) begin
                    w_state_d = (NUM_OUT == 1) ? StIdle : StRelease;
                end
            end
            StRelease: begin
                if (w_req) begin
                    w_state_d = StAssert;
                end else if (r_gap == GapLast && r_stage == StageLast) begin
                    w_state_d = StIdle;
                end
            end
            StIdle: begin
                if (w_req) begin
                    w_state_d = StAssert;
                end
            end
            default: w_state_d = StAssert;
        endcase
    end

    // Counter and reset-output datapath; r_stage is the next output to release.
    always_comb begin
        w_cnt_d   = r_cnt;
        w_gap_d   = r_gap;
        w_stage_d = r_stage;
        w_reset_d = r_reset_out;
        unique case (r_state)
            StAssert: begin
                w_reset_d = '1;
                if (w_req) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CntLast) begin
                    w_reset_d[0] = 1'b0;
                    w_gap_d      = '0;
                    w_stage_d    = StageW'(1);
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StRelease: begin
                if (w_req) begin
                    w_reset_d = '1;
                    w_cnt_d   = '0;
                    w_gap_d   = '0;
                end else if (r_gap == GapLast) begin
                    w_reset_d[r_stage] = 1'b0;
                    w_gap_d            = '0;
                    if (r_stage != StageLast) begin
                        w_stage_d = r_stage + StageW'(1);
                    end
                end else begin
                    w_gap_d = r_gap + GapW'(1);
                end
            end
            StIdle: begin
                if (w_req) begin
                    w_reset_d = '1;
                    w_cnt_d   = '0;
                    w_gap_d   = '0;
                end
            end
            default: begin
                w_reset_d = '1;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        o_reset_out = r_reset_out;
        o_busy      = (r_state != StIdle);
        o_cause     = r_cause;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer at default parameters. Expected values
//   are hand-computed edge counts relative to the edge that starts ASSERT.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_async;
    logic       req_strobe;
    logic [1:0] src_mask;
    logic       cause_clr;
    logic [2:0] reset_out;
    logic       busy;
    logic [3:0] cause;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_async  (req_async),
        .i_req_strobe (req_strobe),
        .i_src_mask   (src_mask),
        .i_cause_clr  (cause_clr),
        .o_reset_out  (reset_out),
        .o_busy       (busy),
        .o_cause      (cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called right after the edge that entered (or restarted) ASSERT.
    task automatic run_release(input string tag);
        tick(15);
        check({tag, " edge15 out"}, 32'(reset_out), 32'h7);
        tick(1);
        check({tag, " edge16 out"}, 32'(reset_out), 32'h6);
        check({tag, " edge16 busy"}, 32'(busy), 32'h1);
        tick(3);
        check({tag, " edge19 out"}, 32'(reset_out), 32'h6);
        tick(1);
        check({tag, " edge20 out"}, 32'(reset_out), 32'h4);
        tick(3);
        check({tag, " edge23 out"}, 32'(reset_out), 32'h4);
        check({tag, " edge23 busy"}, 32'(busy), 32'h1);
        tick(1);
        check({tag, " edge24 out"}, 32'(reset_out), 32'h0);
        check({tag, " edge24 busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_async  = 2'b00;
        req_strobe = 1'b0;
        src_mask   = 2'b00;
        cause_clr  = 1'b0;

        // Power-on reset, then default release timeline.
        tick(3);
        check("por out", 32'(reset_out), 32'h7);
        check("por busy", 32'(busy), 32'h1);
        check("por cause", 32'(cause), 32'h1);
        rst_n = 1'b1;
        run_release("por");
        check("por final cause", 32'(cause), 32'h1);

        // Strobe in IDLE.
        req_strobe = 1'b1;
        tick(1);
        req_strobe = 1'b0;
        check("strobe out", 32'(reset_out), 32'h7);
        check("strobe busy", 32'(busy), 32'h1);
        check("strobe cause", 32'(cause), 32'h3);
        run_release("strobe");

        // Clear alone.
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        check("clr cause", 32'(cause), 32'h0);

        // Async source 1, held 10 cycles: visible on the 3rd edge after rise.
        req_async[1] = 1'b1;
        tick(2);
        check("async edge2 out", 32'(reset_out), 32'h0);
        tick(1);
        check("async edge3 out", 32'(reset_out), 32'h7);
        check("async cause", 32'(cause), 32'h8);
        tick(7);
        req_async[1] = 1'b0;
        tick(2); // synchronised drop sampled here
        run_release("async");

        // Fully masked sources are ignored.
        src_mask  = 2'b11;
        req_async = 2'b11;
        tick(4);
        req_async = 2'b00;
        tick(4);
        check("mask out", 32'(reset_out), 32'h0);
        check("mask busy", 32'(busy), 32'h0);
        check("mask cause", 32'(cause), 32'h8);
        src_mask = 2'b00;

        // Strobe on the edge where reset_out[1] would fall restarts the sequence.
        req_strobe = 1'b1;
        tick(1);
        req_strobe = 1'b0;
        tick(19);
        check("restart edge19 out", 32'(reset_out), 32'h6);
        req_strobe = 1'b1;
        tick(1);
        req_strobe = 1'b0;
        check("restart edge20 out", 32'(reset_out), 32'h7);
        run_release("restart");

        // rst_n mid-RELEASE re-asserts everything.
        req_strobe = 1'b1;
        tick(1);
        req_strobe = 1'b0;
        tick(18);
        check("midrel pre out", 32'(reset_out), 32'h6);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrel out", 32'(reset_out), 32'h7);
        check("midrel busy", 32'(busy), 32'h1);
        check("midrel cause", 32'(cause), 32'h1);

        // Build cause = 0x5, then clear and strobe together.
        req_async[0] = 1'b1;
        tick(3);
        check("cause5", 32'(cause), 32'h5);
        req_async[0] = 1'b0;
        tick(3);
        check("cause5 hold", 32'(cause), 32'h5);
        cause_clr  = 1'b1;
        req_strobe = 1'b1;
        tick(1);
        cause_clr  = 1'b0;
        req_strobe = 1'b0;
        check("clr+strobe cause", 32'(cause), 32'h2);
        check("clr+strobe out", 32'(reset_out), 32'h7);
        run_release("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_SRC, default 2, number of asynchronous reset-request sources; legal 1..8.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth per source; legal 2..4.
REQ-003 Parameter STRETCH_CYCLES, default 16, minimum assert time after the last request drops; legal 2..256.
REQ-004 Parameter NUM_OUT, default 3, number of staged reset outputs; legal 1..4.
REQ-005 Parameter RELEASE_GAP, default 4, cycles between successive output releases; legal 1..64.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 req_async  in  NUM_SRC  asynchronous reset requests, active-high, level-sensitive.
REQ-009 req_strobe  in  1  synchronous single-cycle reset command (e.g. UART reset command strobe), active-high.
REQ-010 src_mask  in  NUM_SRC  1 = ignore corresponding req_async bit.
REQ-011 cause_clr  in  1  synchronous clear of the cause register.
REQ-012 reset_out  out  NUM_OUT  active-high, registered, synchronous reset outputs; bit 0 released first.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 cause  out  NUM_SRC+2  sticky cause: bit0 = power-on (rst_n), bit1 = req_strobe, bit 2+i = req_async[i].

Function
REQ-015 Each req_async bit SHALL pass through its own SYNC_STAGES flip-flop synchroniser before any other use; masking SHALL be applied after the synchroniser.
REQ-016 "Request" SHALL mean any unmasked synchronised source high, or req_strobe high, sampled at a rising edge.
REQ-017 FSM states SHALL be ASSERT, RELEASE and IDLE.
REQ-018 ASSERT: all reset_out high; a request clears the stretch counter; with no request the counter increments; on the STRETCH_CYCLES-th consecutive request-free edge the FSM enters RELEASE and reset_out[0] falls on that edge.
REQ-019 RELEASE: reset_out[k] SHALL fall exactly k*RELEASE_GAP edges after reset_out[0]; on the edge reset_out[NUM_OUT-1] falls the FSM enters IDLE and busy falls on that same edge.
REQ-020 NUM_OUT = 1: ASSERT SHALL go directly to IDLE on the edge reset_out[0] falls.
REQ-021 A request sampled in RELEASE or IDLE SHALL, on that edge, set all reset_out high, clear the counter and enter ASSERT.
REQ-022 req_strobe latency: reset_out high after the edge that samples it; req_async latency: reset_out high on edge SYNC_STAGES+1 after the input rises.
REQ-023 Counters SHALL be sized ceil(log2(max+1)) and SHALL NOT wrap; the stretch counter holds while requests persist.
REQ-024 cause bit for each request source SHALL set on the edge that request is sampled, in any state; masked sources SHALL NOT set cause.
REQ-025 cause_clr clears all cause bits; a cause set in the same cycle wins (bit reads 1).
REQ-026 A source held continuously high SHALL hold reset_out high indefinitely.

Reset
REQ-027 rst_n low at an edge SHALL force state ASSERT, counter 0, all reset_out high, busy high, cause = 1 (bit0 only), synchroniser stages 0.
REQ-028 rst_n low mid-RELEASE SHALL re-assert all released outputs on that edge.
REQ-029 Release after rst_n SHALL follow REQ-018/019, with counting starting at the first edge sampling rst_n high.

Verification
REQ-030 Defaults, rst_n low 3 cycles then high, no requests -> reset_out[0] falls edge 16, [1] edge 20, [2] edge 24; busy low edge 24; cause = 0x1.
REQ-031 In IDLE, req_strobe pulsed 1 cycle -> all reset_out high next edge; cause bit1 set; release 16/20/24 edges after the strobe edge.
REQ-032 req_async[1] raised in IDLE, held 10 cycles, src_mask = 0 -> reset_out high 3 edges after rise; reset_out[0] falls 16 edges after the synchronised drop; cause bit3 set.
REQ-033 src_mask = 2'b11, toggle both req_async -> reset_out stay low, busy low, cause unchanged.
REQ-034 req_strobe at the edge reset_out[1] would fall -> all outputs high, counter restarts, full 16/20/24 sequence repeats.
REQ-035 cause_clr and req_strobe in the same cycle with cause = 0x5 -> cause = 0x2.
